sevenseg_mux_driver: RTL and testbench

- Parametrised multiplexed seven-segment driver.
- Takes NUM_CH binary values on a load/busy handshake and converts each to BCD sequentially using shift-add-3 (double-dabble).
- Commits all results atomically and time-multiplexes NUM_CH*DIG_PER_CH digits onto one shared active-low segment bus.
- Sits between game logic (score, hiscore, timers) and the board's anode and segment pins.

---
 rtl/sevenseg_pkg.sv | 48 ++++
 rtl/sevenseg_bin2bcd.sv | 74 +++++++
 rtl/sevenseg_mux_driver.sv | 205 ++++++++++++++++++++
 tb/tb_sevenseg_mux_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants, FSM encoding and helper functions for the multiplexed seven-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STORE,
        COMMIT
    } state_t;

    // Nibbles needed to hold 2^width-1 in BCD: ceil((width+2)/3).
    function automatic int bcd_nibbles(input int width);
        return (width + 4) / 3;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_bin2bcd.sv
// One-channel shift-add-3 (double-dabble) binary to BCD converter, CH_W shift cycles per start.
// bcd carries the low DIG_PER_CH digits; ovf flags any nonzero digit above them.
module sevenseg_bin2bcd
    import sevenseg_pkg::*;
#(
    parameter int CH_W       = 8,
    parameter int DIG_PER_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CH_W-1:0]         bin,
    output logic                    busy,
    output logic [4*DIG_PER_CH-1:0] bcd,
    output logic                    ovf
);

    localparam int NIB    = bcd_nibbles(CH_W);
    localparam int BCD_W  = 4 * NIB;
    localparam int SHOW_W = 4 * DIG_PER_CH;
    localparam int CNT_W  = $clog2(CH_W + 1);

    logic [CH_W-1:0]  bin_reg;
    logic [BCD_W-1:0] acc_reg;
    logic [BCD_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    logic             last_shift;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                        acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign last_shift = (cnt_reg == CNT_W'(CH_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            bin_reg    <= bin;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            acc_reg <= {acc_adj[BCD_W-2:0], bin_reg[CH_W-1]};
            bin_reg <= bin_reg << 1;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_shift) begin
                active_reg <= 1'b0;
            end
        end
    end

    // Drops on the final shift cycle so the sequencer moves on without a dead cycle.
    assign busy = active_reg && !last_shift;

    generate
        if (BCD_W > SHOW_W) begin : g_trunc
            assign bcd = acc_reg[SHOW_W-1:0];
            assign ovf = |acc_reg[BCD_W-1:SHOW_W];
        end else begin : g_ext
            assign bcd = SHOW_W'(acc_reg);
            assign ovf = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Multiplexed seven-segment driver: sequential BCD conversion of NUM_CH values, atomic commit, digit scan.
// Optional blink support is compiled in with SEVENSEG_BLINK_EN.
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 8,
    parameter int DIG_PER_CH = 4,
    parameter int REFRESH_W  = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUM_CH*CH_W-1:0]       values,
`ifdef SEVENSEG_BLINK_EN
    input  logic [NUM_CH-1:0]            blink,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [6:0]                   seg,
    output logic [NUM_CH*DIG_PER_CH-1:0] an
);

    localparam int NUM_DIG  = NUM_CH * DIG_PER_CH;
    localparam int DIG_W    = 4 * DIG_PER_CH;
    localparam int IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                state_reg, state_next;
    logic [CH_IDX_W-1:0]   ch_reg;
    logic [CH_IDX_W-1:0]   ch_inc;
    logic [CH_W-1:0]       shadow_reg  [NUM_CH];
    logic [DIG_W-1:0]      staging_reg [NUM_CH];
    logic [DIG_W-1:0]      disp_reg    [NUM_CH];
    logic [NUM_CH-1:0]     stg_ovf_reg;
    logic [NUM_CH-1:0]     disp_ovf_reg;

    logic                  conv_start;
    logic [CH_W-1:0]       conv_bin;
    logic                  conv_busy;
    logic [DIG_W-1:0]      conv_bcd;
    logic                  conv_ovf;

    logic [REFRESH_W-1:0]  refresh_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [NUM_DIG-1:0]    an_reg;
    logic [6:0]            seg_reg;
    logic [6:0]            digit_seg [NUM_DIG];

    assign ch_inc = ch_reg + 1'b1;

    sevenseg_bin2bcd #(
        .CH_W       (CH_W),
        .DIG_PER_CH (DIG_PER_CH)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The converter is kicked from IDLE (channel 0, straight from the inputs) and from STORE (next channel).
    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        conv_bin   = values[CH_W-1:0];
        case (state_reg)
            IDLE: begin
                if (load) begin
                    conv_start = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!conv_busy) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                if (ch_reg == CH_IDX_W'(NUM_CH - 1)) begin
                    state_next = COMMIT;
                end else begin
                    conv_start = 1'b1;
                    conv_bin   = shadow_reg[ch_inc];
                    state_next = SHIFT;
                end
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_reg       <= '0;
            stg_ovf_reg  <= '0;
            disp_ovf_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_reg[i]  <= '0;
                staging_reg[i] <= '0;
                disp_reg[i]    <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        ch_reg <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            shadow_reg[i] <= values[i*CH_W +: CH_W];
                        end
                    end
                end
                STORE: begin
                    staging_reg[ch_reg] <= conv_bcd;
                    stg_ovf_reg[ch_reg] <= conv_ovf;
                    ch_reg              <= ch_inc;
                end
                COMMIT: begin
                    disp_ovf_reg <= stg_ovf_reg;
                    for (int i = 0; i < NUM_CH; i++) begin
                        disp_reg[i] <= staging_reg[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == COMMIT);

`ifdef SEVENSEG_BLINK_EN
    logic [23:0] blink_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_digit
            localparam int C = gi / DIG_PER_CH;
            localparam int P = gi % DIG_PER_CH;
            logic [3:0] nib;
            logic       upper_zero;
            logic       blink_off;

            assign nib        = disp_reg[C][P*4 +: 4];
            assign upper_zero = (disp_reg[C][DIG_W-1:P*4] == '0);
`ifdef SEVENSEG_BLINK_EN
            assign blink_off  = blink[C] && !blink_cnt_reg[23];
`else
            assign blink_off  = 1'b0;
`endif

            always_comb begin
                digit_seg[gi] = seg_decode(nib);
                if (blink_off) begin
                    digit_seg[gi] = SEG_BLANK;
                end else if (disp_ovf_reg[C]) begin
                    digit_seg[gi] = SEG_DASH;
                end else if ((P != 0) && upper_zero) begin
                    digit_seg[gi] = SEG_BLANK;
                end
            end
        end
    endgenerate

    // an and seg are both registered from idx_reg so they always switch together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_reg <= '0;
            idx_reg     <= '0;
            an_reg      <= '1;
            seg_reg     <= SEG_BLANK;
        end else begin
            refresh_reg <= refresh_reg + 1'b1;
            if (refresh_reg == '1) begin
                idx_reg <= (idx_reg == IDX_W'(NUM_DIG - 1)) ? '0 : idx_reg + 1'b1;
            end
            an_reg  <= ~(NUM_DIG'(1) << idx_reg);
            seg_reg <= digit_seg[idx_reg];
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed test of sevenseg_mux_driver: default 2x4-digit instance plus a 2x2-digit instance for overflow.
// Expected segment patterns are hand-computed constants.
module tb_sevenseg_mux_driver;

    logic        clk;
    logic        rst_n;
    logic        load1, load2;
    logic [15:0] values1, values2;
    logic        busy1, busy2;
    logic        done1, done2;
    logic [6:0]  seg1, seg2;
    logic [7:0]  an1;
    logic [3:0]  an2;
`ifdef SEVENSEG_BLINK_EN
    logic [1:0]  blink1, blink2;
`endif

    int checks = 0;
    int errors = 0;

    sevenseg_mux_driver #(
        .NUM_CH(2), .CH_W(8), .DIG_PER_CH(4), .REFRESH_W(3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load1),
        .values (values1),
`ifdef SEVENSEG_BLINK_EN
        .blink  (blink1),
`endif
        .busy   (busy1),
        .done   (done1),
        .seg    (seg1),
        .an     (an1)
    );

    sevenseg_mux_driver #(
        .NUM_CH(2), .CH_W(8), .DIG_PER_CH(2), .REFRESH_W(3)
    ) dut_narrow (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load2),
        .values (values2),
`ifdef SEVENSEG_BLINK_EN
        .blink  (blink2),
`endif
        .busy   (busy2),
        .done   (done2),
        .seg    (seg2),
        .an     (an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Issue a one-cycle load and count busy/done cycles until busy falls.
    task automatic convert(input int sel, input logic [15:0] v,
                           output int nb, output int nd, output int last_done);
        logic b, d;
        nb = 0; nd = 0; last_done = 0;
        if (sel == 0) begin values1 = v; load1 = 1'b1; end
        else          begin values2 = v; load2 = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            load1 = 1'b0;
            load2 = 1'b0;
            b = (sel == 0) ? busy1 : busy2;
            d = (sel == 0) ? done1 : done2;
            if (b) begin
                nb++;
                if (d) begin nd++; last_done = nb; end
            end else if (nb > 0) begin
                break;
            end
        end
    endtask

    // Wait for each anode in turn and compare its segment pattern; exp holds digit k at [k*7 +: 7].
    task automatic check_display(input int sel, input string tag, input int ndig, input logic [55:0] exp);
        logic [7:0] want_an;
        logic [7:0] cur_an;
        logic [6:0] cur_seg;
        int t;
        @(negedge clk);
        for (int k = 0; k < ndig; k++) begin
            want_an = ~(8'b1 << k);
            if (sel != 0) want_an[7:4] = 4'h0;
            t = 0;
            cur_an = (sel == 0) ? an1 : {4'h0, an2};
            while (cur_an !== want_an && t < 200) begin
                @(negedge clk);
                t++;
                cur_an = (sel == 0) ? an1 : {4'h0, an2};
            end
            if (t >= 200) check($sformatf("%s_an%0d_timeout", tag, k), cur_an, want_an);
            cur_seg = (sel == 0) ? seg1 : seg2;
            check($sformatf("%s_d%0d", tag, k), cur_seg, exp[k*7 +: 7]);
        end
    endtask

    initial begin
        int nb, nd, ld;
        rst_n = 1'b0; load1 = 1'b0; load2 = 1'b0; values1 = '0; values2 = '0;
`ifdef SEVENSEG_BLINK_EN
        blink1 = 2'b00; blink2 = 2'b00;
`endif
        repeat (2) @(negedge clk);
        check("rst_an", an1, 8'hFF);
        check("rst_seg", seg1, 7'h7F);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_an_narrow", an2, 4'hF);
        rst_n = 1'b1;
        check_display(0, "zeros", 8, {7'h7F,7'h7F,7'h7F,7'h40, 7'h7F,7'h7F,7'h7F,7'h40});
        check_display(1, "zeros_n", 4, {28'h0, 7'h7F,7'h40, 7'h7F,7'h40});

        // ch0 = 7, ch1 = 42
        convert(0, {8'd42, 8'd7}, nb, nd, ld);
        check("v42_7_busy_cycles", nb, 19);
        check("v42_7_done_count", nd, 1);
        check("v42_7_done_last", ld, 19);
        check_display(0, "v42_7", 8, {7'h7F,7'h7F,7'h19,7'h24, 7'h7F,7'h7F,7'h7F,7'h78});

        // ch0 = 100 (inner zero shown), ch1 = 255
        convert(0, {8'd255, 8'd100}, nb, nd, ld);
        check("v255_100_busy_cycles", nb, 19);
        check_display(0, "v255_100", 8, {7'h7F,7'h24,7'h12,7'h12, 7'h7F,7'h79,7'h40,7'h40});

        // two digits per channel: 150 overflows ch0, ch1 = 34 shows normally
        convert(1, {8'd34, 8'd150}, nb, nd, ld);
        check("narrow_busy_cycles", nb, 19);
        check("narrow_done_count", nd, 1);
        check_display(1, "ovf150", 4, {28'h0, 7'h30,7'h19, 7'h3F,7'h3F});

        // load held high: ignored while busy, re-triggers after one idle cycle
        values1 = {8'd200, 8'd200};
        load1 = 1'b1;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy1) nb++;
            else if (nb > 0) break;
        end
        check("held_busy_cycles", nb, 19);
        check("held_idle_gap", busy1, 1'b0);
        @(negedge clk);
        check("held_retrigger", busy1, 1'b1);
        repeat (4) @(negedge clk);
        check("held_mid_shift_busy", busy1, 1'b1);
        rst_n = 1'b0;
        load1 = 1'b0;
        @(negedge clk);
        check("midrst_an", an1, 8'hFF);
        check("midrst_busy", busy1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy1, 1'b0);
        check_display(0, "postrst", 8, {7'h7F,7'h7F,7'h7F,7'h40, 7'h7F,7'h7F,7'h7F,7'h40});

        convert(0, {8'd42, 8'd7}, nb, nd, ld);
        check("reload_busy_cycles", nb, 19);
        check_display(0, "reload", 8, {7'h7F,7'h7F,7'h19,7'h24, 7'h7F,7'h7F,7'h7F,7'h78});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
